pio_out_bank: RTL

PIO_OUT_BANK -- requirements
Module: pio_out_bank

---
 rtl/pio_out_bank_pkg.sv | 19 +
 rtl/pio_out_chan.sv | 102 ++++++++++
 rtl/pio_out_bank.sv | 101 ++++++++++
 3 files changed

// File: rtl/pio_out_bank_pkg.sv
// pio_out_bank_pkg
// Shared constants for the PIO output bank: register offsets within a channel's
// four-word window and the width of the per-channel pulse counter.
// Imported by pio_out_chan and pio_out_bank.

package pio_out_bank_pkg;

    // Register offsets (address[1:0])
    localparam logic [1:0] OFF_DATA  = 2'd0;
    localparam logic [1:0] OFF_SET   = 2'd1;
    localparam logic [1:0] OFF_CLEAR = 2'd2;
    localparam logic [1:0] OFF_PULSE = 2'd3;

    // Pulse counter width; PULSE_CYCLES must fit in it (1..65535)
    localparam int CNT_W = 16;

    typedef logic [1:0] offset_t;

endpackage

// File: rtl/pio_out_chan.sv
// pio_out_chan
// State for one output channel: the data register that drives the pins and,
// when PIO_OUT_BANK_PULSE_EN is defined, the pulse mask, down-counter and
// busy flag.
//
// Ports:
//   clk      in   clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   wr_en    in   write strobe already qualified for this channel
//   offset   in   register offset of the write
//   wdata    in   write data, WIDTH bits
//   data     out  channel data register (drives out_port directly)
//   busy     out  pulse in progress (constant 0 without the pulse feature)
//
// Configuration macro: PIO_OUT_BANK_PULSE_EN

module pio_out_chan
    import pio_out_bank_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
    parameter int               PULSE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  offset_t          offset,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] data,
    output logic             busy
);

    // New data value for a DATA/SET/CLEAR write.
    function automatic logic [WIDTH-1:0] apply_write(input logic [WIDTH-1:0] cur,
                                                     input offset_t          off,
                                                     input logic [WIDTH-1:0] wd);
        logic [WIDTH-1:0] nxt;
        case (off)
            OFF_DATA:  nxt = wd;
            OFF_SET:   nxt = cur | wd;
            OFF_CLEAR: nxt = cur & ~wd;
            default:   nxt = cur;
        endcase
        return nxt;
    endfunction

    logic plain_wr;
    assign plain_wr = wr_en && (offset != OFF_PULSE);

`ifdef PIO_OUT_BANK_PULSE_EN

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES);

    logic [WIDTH-1:0] mask;
    logic [CNT_W-1:0] cnt;

    // Priority: a plain write always wins and cancels any pending restore,
    // even one that would have landed on this same edge. A PULSE write to a
    // busy channel falls through to the countdown branch, i.e. is ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data <= RESET_VALUE;
            mask <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (plain_wr) begin
            data <= apply_write(data, offset, wdata);
            cnt  <= '0;
            busy <= 1'b0;
        end else if (wr_en && !busy) begin
            data <= data ^ wdata;
            mask <= wdata;
            cnt  <= PULSE_LOAD;
            busy <= 1'b1;
        end else if (busy) begin
            // Counter reaching zero on this edge restores the toggled bits,
            // so the output stays toggled for exactly PULSE_CYCLES cycles.
            if (cnt == CNT_W'(1)) begin
                data <= data ^ mask;
                cnt  <= '0;
                busy <= 1'b0;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

`else

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data <= RESET_VALUE;
        end else if (plain_wr) begin
            data <= apply_write(data, offset, wdata);
        end
    end

    assign busy = 1'b0;

`endif

endmodule

// File: rtl/pio_out_bank.sv
// pio_out_bank
// Avalon-MM slave controlling CHANNELS parallel output registers of WIDTH bits.
// Each channel has four registers: DATA (replace), SET (OR), CLEAR (AND-NOT)
// and PULSE (timed XOR toggle). Reads are combinational with zero latency.
//
// Ports:
//   clk         in   clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   address     in   {channel index, register offset[1:0]}
//   chipselect  in   slave select
//   write_n     in   active-low write strobe
//   writedata   in   32-bit write data (bits above WIDTH ignored)
//   readdata    out  32-bit read data (zero-extended)
//   out_port    out  channel c on bits [c*WIDTH +: WIDTH]
//
// Configuration macro: PIO_OUT_BANK_PULSE_EN enables the PULSE register logic.

module pio_out_bank
    import pio_out_bank_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter int               CHANNELS     = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
    parameter int               PULSE_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [$clog2(CHANNELS)+1:0] address,
    input  logic                        chipselect,
    input  logic                        write_n,
    input  logic [31:0]                 writedata,
    output logic [31:0]                 readdata,
    output logic [CHANNELS*WIDTH-1:0]   out_port
);

    // At least one index bit so CHANNELS=1 still has a well-formed select.
    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [IDX_W-1:0]   chan_idx;
    offset_t            offset;
    logic               chan_valid;
    logic               wr;
    logic [WIDTH-1:0]   wdata;
    logic [WIDTH-1:0]   chan_data [CHANNELS];
    logic [CHANNELS-1:0] chan_busy;
    logic [WIDTH-1:0]   sel_data;
    logic               sel_busy;

    if (CHANNELS > 1) begin : g_idx
        assign chan_idx = address[$clog2(CHANNELS)+1:2];
    end else begin : g_idx_one
        assign chan_idx = '0;
    end

    assign offset = address[1:0];

    // Non-power-of-two channel counts leave unused index codes.
    assign chan_valid = (32'(chan_idx) < 32'(CHANNELS));
    assign wr         = chipselect && !write_n && chan_valid;
    assign wdata      = writedata[WIDTH-1:0];

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        pio_out_chan #(
            .WIDTH        (WIDTH),
            .RESET_VALUE  (RESET_VALUE),
            .PULSE_CYCLES (PULSE_CYCLES)
        ) u_chan (
            .clk     (clk),
            .reset_n (reset_n),
            .wr_en   (wr && (chan_idx == IDX_W'(c))),
            .offset  (offset),
            .wdata   (wdata),
            .data    (chan_data[c]),
            .busy    (chan_busy[c])
        );

        assign out_port[c*WIDTH +: WIDTH] = chan_data[c];
    end

    // Read mux: decoded from address alone, chipselect does not gate it.
    always_comb begin
        sel_data = '0;
        sel_busy = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (chan_idx == IDX_W'(c)) begin
                sel_data = chan_data[c];
                sel_busy = chan_busy[c];
            end
        end

        readdata = '0;
        if (chan_valid) begin
            if (offset == OFF_PULSE) begin
                readdata = {31'b0, sel_busy};
            end else begin
                readdata[WIDTH-1:0] = sel_data;
            end
        end
    end

endmodule
